// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control bundle layout, ALU op encodings and the bubble constant.
package pipeline_pkg;

    localparam int unsigned CTRL_W          = 10;
    localparam int unsigned CTRL_ALU_OP_LSB = 0;
    localparam int unsigned CTRL_BRANCH     = 4;
    localparam int unsigned CTRL_ALU_SRC    = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 6;
    localparam int unsigned CTRL_MEM_WRITE  = 7;
    localparam int unsigned CTRL_MEM_READ   = 8;
    localparam int unsigned CTRL_REG_WRITE  = 9;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    function automatic logic [CTRL_W-1:0] make_ctrl(
        input logic    reg_write_en,
        input logic    mem_read,
        input logic    mem_write,
        input logic    mem_to_reg,
        input logic    alu_src,
        input logic    branch,
        input alu_op_e alu_op
    );
        logic [CTRL_W-1:0] c;
        c = CTRL_NOP;
        c[CTRL_REG_WRITE]                    = reg_write_en;
        c[CTRL_MEM_READ]                     = mem_read;
        c[CTRL_MEM_WRITE]                    = mem_write;
        c[CTRL_MEM_TO_REG]                   = mem_to_reg;
        c[CTRL_ALU_SRC]                      = alu_src;
        c[CTRL_BRANCH]                       = branch;
        c[CTRL_ALU_OP_LSB+3:CTRL_ALU_OP_LSB] = alu_op;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module load_use_detector (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    // A matching index only counts when the source is actually read.
    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard    = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid
                       && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, EX-driven flush and saturating event counters.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    output logic              ID_EX_valid,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [4:0]        ID_EX_rs1,
    output logic [4:0]        ID_EX_rs2,
    output logic [4:0]        ID_EX_rd,
    output logic [XLEN-1:0]   ID_EX_rs1_data,
    output logic [XLEN-1:0]   ID_EX_rs2_data,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic              ID_EX_reg_write_en,
    output logic              ID_EX_mem_read,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              if_id_flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic hazard;
    logic stall;
    logic capture;

    load_use_detector u_detector (
        .ex_valid    (ID_EX_valid),
        .ex_mem_read (ID_EX_mem_read),
        .ex_rd       (ID_EX_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (hazard)
    );

    assign ID_EX_reg_write_en = ID_EX_ctrl[CTRL_REG_WRITE];
    assign ID_EX_mem_read     = ID_EX_ctrl[CTRL_MEM_READ];

    // Flush outranks the stall: a flushed consumer must not freeze the front end.
    assign stall          = hazard && !ex_flush;
    assign capture        = !ex_flush && !hazard;
    assign pc_write_en    = !stall;
    assign if_id_write_en = !stall;
    assign if_id_flush    = ex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_ctrl     <= CTRL_NOP;
        end else if (capture) begin
            ID_EX_valid    <= id_valid;
            ID_EX_pc       <= id_pc;
            ID_EX_rs1      <= id_rs1;
            ID_EX_rs2      <= id_rs2;
            ID_EX_rd       <= id_rd;
            ID_EX_rs1_data <= id_rs1_data;
            ID_EX_rs2_data <= id_rs2_data;
            ID_EX_imm      <= id_imm;
            ID_EX_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
        end else begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_ctrl     <= CTRL_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (ex_flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
